// File: rtl/seq_code_monitor.sv
// seq_code_monitor
// Watches the code stream of a free-running +1-per-clock sequencer. It
// acquires lock after LOCK_LEN consecutive correct steps and drops lock after
// LOSS_LEN consecutive bad steps. While locked it counts completed laps and
// bad steps; both counters saturate.
//
// Input handshake: valid-only, with no backpressure. code_in is consumed on a
// rising Clk edge exactly when code_valid is high. While code_valid is low,
// code_in is ignored and nothing changes except a pending clr_cnt.
//
// Debug visibility: mon_state carries the raw FSM state
// (HUNT=00, SYNC=01, LOCKED=10, SLIP=11).
module seq_code_monitor #(
    parameter int CODE_W   = 3,
    parameter int LOCK_LEN = 4,
    parameter int LOSS_LEN = 2,
    parameter int LAP_W    = 8,
    parameter int ERR_W    = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              mismatch,
    output logic [LAP_W-1:0]  lap_count,
    output logic [ERR_W-1:0]  err_count,
    output logic [1:0]        mon_state,
    output logic [CODE_W-1:0] expected
);

    // FSM encoding matches the mon_state output directly.
    localparam logic [1:0] ST_HUNT   = 2'b00;
    localparam logic [1:0] ST_SYNC   = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;
    localparam logic [1:0] ST_SLIP   = 2'b11;

    // Run-length counters are just wide enough to reach their targets.
    localparam int GOOD_W = $clog2(LOCK_LEN + 1);
    localparam int BAD_W  = $clog2(LOSS_LEN + 1);

    localparam logic [GOOD_W-1:0] GOOD_ONE    = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_LEN);
    localparam logic [BAD_W-1:0]  BAD_ONE     = BAD_W'(1);
    localparam logic [BAD_W-1:0]  BAD_TARGET  = BAD_W'(LOSS_LEN);
    localparam logic [CODE_W-1:0] CODE_ONE    = CODE_W'(1);
    localparam logic [LAP_W-1:0]  LAP_ONE     = LAP_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE     = ERR_W'(1);

    // Registered state.
    logic [1:0]        state_q;
    logic [CODE_W-1:0] prev_q;
    logic [GOOD_W-1:0] good_q;
    logic [BAD_W-1:0]  bad_q;

    // Next-state values and per-sample events.
    logic [1:0]        state_d;
    logic [GOOD_W-1:0] good_d;
    logic [BAD_W-1:0]  bad_d;
    logic              mis_d;
    logic              err_inc;
    logic              lap_inc;

    // Step-check helpers.
    logic [CODE_W-1:0] prev_plus_one;
    logic              step_ok;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_inc;

    assign mon_state = state_q;

    // Work out the successor of the last accepted code and whether this sample matches it.
    always_comb begin
        prev_plus_one = prev_q + CODE_ONE;
        step_ok       = (code_in == prev_plus_one);
        good_inc      = good_q + GOOD_ONE;
        bad_inc       = bad_q + BAD_ONE;
    end

    // Next-state logic. Every decision is gated by a valid sample.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        mis_d   = 1'b0;
        err_inc = 1'b0;
        lap_inc = 1'b0;
        if (code_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // The first sample only seeds prev_code; no comparison is made.
                    state_d = ST_SYNC;
                    good_d  = '0;
                    bad_d   = '0;
                end
                ST_SYNC: begin
                    if (step_ok) begin
                        if (good_inc == GOOD_TARGET) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_inc;
                        end
                    end else begin
                        // Bad steps before lock are silent. They only restart the run.
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (step_ok) begin
                        lap_inc = (code_in == '0);
                    end else begin
                        mis_d   = 1'b1;
                        err_inc = 1'b1;
                        if (LOSS_LEN == 1) begin
                            state_d = ST_SYNC;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            state_d = ST_SLIP;
                            bad_d   = BAD_ONE;
                        end
                    end
                end
                ST_SLIP: begin
                    if (step_ok) begin
                        // One correct step is enough to recover from a slip.
                        state_d = ST_LOCKED;
                        bad_d   = '0;
                        lap_inc = (code_in == '0);
                    end else begin
                        mis_d   = 1'b1;
                        err_inc = 1'b1;
                        if (bad_inc == BAD_TARGET) begin
                            state_d = ST_SYNC;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // FSM, run counters, prev_code and the registered status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_HUNT;
            prev_q   <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            mismatch <= 1'b0;
            locked   <= 1'b0;
            expected <= '0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            mismatch <= mis_d;
            locked   <= (state_d == ST_LOCKED) || (state_d == ST_SLIP);
            if (code_valid) begin
                prev_q   <= code_in;
                expected <= code_in + CODE_ONE;
            end
        end
    end

    // Lap counter. Clear beats increment. It saturates at all-ones.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lap_count <= '0;
        end else if (clr_cnt) begin
            lap_count <= '0;
        end else if (lap_inc && (lap_count != '1)) begin
            lap_count <= lap_count + LAP_ONE;
        end
    end

    // Error counter. Clear beats increment. It saturates at all-ones.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_count <= '0;
        end else if (clr_cnt) begin
            err_count <= '0;
        end else if (err_inc && (err_count != '1)) begin
            err_count <= err_count + ERR_ONE;
        end
    end

endmodule

// File: tb/tb_seq_code_monitor.sv
// Testbench for seq_code_monitor. A behavioural model follows the monitor's
// rules using plain integers and modulo arithmetic. Directed phases pin
// hand-computed values. A random phase is then checked every cycle against
// the model. A second instance with ERR_W=2 covers saturation of the error
// counter.
module tb_seq_code_monitor;

    localparam int LOCK_LEN = 4;
    localparam int LOSS_LEN = 2;

    // Clock and reset.
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [2:0] code_in = '0;
    logic       code_valid = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       locked, mismatch;
    logic [7:0] lap_count, err_count;
    logic [1:0] mon_state;
    logic [2:0] expected;

    logic       locked2, mismatch2;
    logic [7:0] lap_count2;
    logic [1:0] err_count2;
    logic [1:0] mon_state2;
    logic [2:0] expected2;

    seq_code_monitor #(.CODE_W(3), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN), .LAP_W(8), .ERR_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .code_in(code_in), .code_valid(code_valid), .clr_cnt(clr_cnt),
        .locked(locked), .mismatch(mismatch), .lap_count(lap_count), .err_count(err_count),
        .mon_state(mon_state), .expected(expected)
    );

    seq_code_monitor #(.CODE_W(3), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN), .LAP_W(8), .ERR_W(2)) dut_e2 (
        .Clk(Clk), .Reset(Reset), .code_in(code_in), .code_valid(code_valid), .clr_cnt(clr_cnt),
        .locked(locked2), .mismatch(mismatch2), .lap_count(lap_count2), .err_count(err_count2),
        .mon_state(mon_state2), .expected(expected2)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    int last_c = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Behavioural model. mode: 0 hunting, 1 syncing, 2 locked, 3 slipping.
    int m_mode, m_prev, m_good, m_bad, m_lap, m_err, m_err2, m_exp;
    bit m_mis;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_mode = 0; m_prev = 0; m_good = 0; m_bad = 0;
            m_lap = 0; m_err = 0; m_err2 = 0; m_exp = 0; m_mis = 0;
        end else begin
            bit ok, bad_step, lap_step;
            ok = 0; bad_step = 0; lap_step = 0;
            if (code_valid) begin
                ok = (int'(code_in) == (m_prev + 1) % 8);
                if (m_mode == 0) begin
                    m_mode = 1; m_good = 0;
                end else if (m_mode == 1) begin
                    if (ok) begin
                        m_good++;
                        if (m_good == LOCK_LEN) begin m_mode = 2; m_good = 0; end
                    end else m_good = 0;
                end else begin
                    if (ok) begin
                        lap_step = (code_in == 0);
                        m_mode = 2; m_bad = 0;
                    end else begin
                        bad_step = 1;
                        m_bad = (m_mode == 2) ? 1 : m_bad + 1;
                        if (m_bad >= LOSS_LEN) begin
                            m_mode = 1; m_good = 0; m_bad = 0;
                        end else m_mode = 3;
                    end
                end
                m_prev = int'(code_in);
                m_exp = (m_prev + 1) % 8;
            end
            m_mis = bad_step;
            if (clr_cnt) begin
                m_lap = 0; m_err = 0; m_err2 = 0;
            end else begin
                if (lap_step && m_lap < 255) m_lap++;
                if (bad_step && m_err < 255) m_err++;
                if (bad_step && m_err2 < 3) m_err2++;
            end
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge Clk) begin
        if (cmp_en && !Reset) begin
            chk("locked", int'(locked), (m_mode >= 2) ? 1 : 0);
            chk("mismatch", int'(mismatch), int'(m_mis));
            chk("lap_count", int'(lap_count), m_lap);
            chk("err_count", int'(err_count), m_err);
            chk("mon_state", int'(mon_state), m_mode);
            chk("expected", int'(expected), m_exp);
            chk("err_count_w2", int'(err_count2), m_err2);
        end
    end

    // Driver: present one input set for one clock, then return just after the edge.
    task automatic send(input int c, input bit v = 1'b1, input bit clr = 1'b0);
        @(negedge Clk);
        code_in = 3'(c);
        code_valid = v;
        clr_cnt = clr;
        if (v) last_c = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_mismatch"}, int'(mismatch), 0);
        chk({tag, "_lap"}, int'(lap_count), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_state"}, int'(mon_state), 0);
        chk({tag, "_expected"}, int'(expected), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge Clk);
        #1;
        chk_all_zero("reset");
        @(negedge Clk);
        Reset = 1'b0;
        cmp_en = 1'b1;

        // Acquire lock.
        send(0);
        chk("hunt_to_sync", int'(mon_state), 1);
        chk("sync_expected", int'(expected), 1);
        for (int c = 1; c <= 3; c++) send(c);
        chk("not_locked_yet", int'(locked), 0);
        send(4);
        chk("lock_locked", int'(locked), 1);
        chk("lock_state", int'(mon_state), 2);
        chk("lock_expected", int'(expected), 5);

        // Lap counting.
        for (int c = 5; c <= 8; c++) send(c % 8);
        chk("first_lap", int'(lap_count), 1);
        for (int i = 1; i <= 16; i++) send(i % 8);
        chk("three_laps", int'(lap_count), 3);
        chk("no_errors", int'(err_count), 0);

        // Single glitch.
        send(1); send(2); send(3); send(6);
        chk("glitch_mismatch", int'(mismatch), 1);
        chk("glitch_err", int'(err_count), 1);
        chk("glitch_slip", int'(mon_state), 3);
        chk("glitch_locked", int'(locked), 1);
        send(7);
        chk("glitch_recover", int'(mon_state), 2);
        chk("glitch_pulse_end", int'(mismatch), 0);
        send(0);
        chk("glitch_lap", int'(lap_count), 4);

        // Lock loss and reacquire.
        send(1); send(2); send(3); send(6);
        chk("loss_mis1", int'(mismatch), 1);
        send(2);
        chk("loss_mis2", int'(mismatch), 1);
        chk("loss_err", int'(err_count), 3);
        chk("loss_state", int'(mon_state), 1);
        chk("loss_locked", int'(locked), 0);
        send(3); send(4); send(5);
        chk("relock_pending", int'(locked), 0);
        send(6);
        chk("relock", int'(locked), 1);

        // Gaps: valid low with garbage codes.
        for (int i = 0; i < 5; i++) send($urandom_range(0, 7), 1'b0);
        chk("gap_state", int'(mon_state), 2);
        chk("gap_expected", int'(expected), 7);
        chk("gap_lap", int'(lap_count), 4);
        chk("gap_mis", int'(mismatch), 0);
        send(7);
        chk("gap_resume", int'(mon_state), 2);

        // Five bad steps, each followed by a recovering correct step.
        for (int i = 0; i < 5; i++) begin
            int b;
            b = (last_c + 3) % 8;
            send(b);
            send((b + 1) % 8);
        end
        chk("sat_err8", int'(err_count), 8);
        chk("sat_err2", int'(err_count2), 3);

        // Asynchronous reset between edges.
        send(0, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge Clk);
        Reset = 1'b0;

        // Clear has priority over a same-cycle lap and error.
        for (int c = 0; c <= 7; c++) send(c);
        chk("clr_pre_locked", int'(mon_state), 2);
        send(0, 1'b1, 1'b1);
        chk("clr_lap", int'(lap_count), 0);
        send(5, 1'b1, 1'b1);
        chk("clr_err", int'(err_count), 0);
        chk("clr_keeps_state", int'(mon_state), 3);

        // Random phase: a mostly correct stream with gaps, glitches, clears and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int c;
            bit v, clr;
            @(negedge Clk);
            if ($urandom_range(0, 499) == 0) begin
                Reset = 1'b1;
                code_valid = 1'b0;
                @(negedge Clk);
                Reset = 1'b0;
            end
            v = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : (last_c + 1) % 8;
            clr = ($urandom_range(0, 99) == 0);
            code_in = 3'(c);
            code_valid = v;
            clr_cnt = clr;
            if (v) last_c = c;
        end
        @(negedge Clk);
        code_valid = 1'b0;
        clr_cnt = 1'b0;
        repeat (2) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_code_monitor.md
Name: seq_code_monitor

Overview:
- Downstream consumer of the 3-bit state code stream produced by the free-running 8-state Moore sequencer (S0..S7, +1 per clock, 7 wraps to 0).
- Checks that each new code is the previous code +1 mod 2^CODE_W, acquires and loses lock with hysteresis, counts completed laps, and counts/flags sequence errors.
- Output feeds testbench scoreboards and status LEDs.

Parameters:
- CODE_W, 3, width of monitored code
- LOCK_LEN, 4, consecutive correct steps in SYNC required to lock (>=1)
- LOSS_LEN, 2, consecutive bad steps in LOCKED/SLIP required to lose lock (>=1)
- LAP_W, 8, lap counter width
- ERR_W, 8, error counter width

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- code_in  in  CODE_W  code from upstream sequencer
- code_valid  in  1  code_in sampled only when high
- clr_cnt  in  1  synchronous clear of lap_count/err_count
- locked  out  1  high in LOCKED or SLIP
- mismatch  out  1  one-cycle pulse per bad step while locked
- lap_count  out  LAP_W  completed laps while locked, saturating
- err_count  out  ERR_W  bad steps while locked, saturating
- mon_state  out  2  HUNT=00, SYNC=01, LOCKED=10, SLIP=11
- expected  out  CODE_W  prev_code+1 mod 2^CODE_W; 0 in HUNT

Behaviour:
- Interface: one clock (Clk); Reset is asynchronous and active-high.
- Reset: all outputs and internal registers are 0; state HUNT; prev_code, good_cnt, and bad_cnt are 0. Outputs clear immediately on Reset assertion, without a clock edge.
- All outputs are registered. Results of a sample taken on edge N are visible after edge N.
- code_valid=0: no state, counter, or prev_code change; mismatch=0.
- Step correct when code_in == (prev_code+1) mod 2^CODE_W. prev_code <= code_in on every valid sample in every state.
- HUNT, valid sample: capture prev_code; go to SYNC; good_cnt=0. No comparison is made.
- SYNC, correct step: good_cnt+1. When it reaches LOCK_LEN, go to LOCKED and clear good_cnt.
- SYNC, bad step: good_cnt=0; stay in SYNC. No mismatch pulse; err_count unchanged.
- LOCKED, correct step: stay in LOCKED.
- LOCKED, bad step: mismatch=1; err_count+1; bad_cnt=1. Go to SYNC if LOSS_LEN==1, else SLIP.
- SLIP, correct step: return to LOCKED; bad_cnt=0.
- SLIP, bad step: mismatch=1; err_count+1; bad_cnt+1. When bad_cnt reaches LOSS_LEN, go to SYNC with good_cnt=0 and bad_cnt=0.
- Lap: in LOCKED or SLIP, a correct step with code_in==0 increments lap_count. The step that completes lock never counts a lap.
- Counters saturate at all-ones; no wrap.
- clr_cnt zeroes both counters on the next edge and has priority over same-cycle increments. It does not affect state.
- locked = (mon_state==LOCKED || mon_state==SLIP).
- Reset mid-operation: return to HUNT; counters are lost.

Test Plan:
1. Acquire lock (LOCK_LEN=4). Reset, then valid stream 0,1,2,3,4,5…, one per clock.
   - HUNT→SYNC after code 0.
   - locked=1 and mon_state=10 after the edge sampling code 4.
   - expected=5 at that point.
2. Lap count. Continue the locked stream through 7,0.
   - lap_count=1 after code 0 is sampled; 3 after two more full laps.
   - err_count=0 and mismatch never high.
3. Single glitch (LOSS_LEN=2). While locked, send …2,3,6,7,0.
   - mismatch high exactly one cycle after 6 is sampled; err_count=1; mon_state=11.
   - Code 7 is correct (6+1), so state returns to 10.
   - locked stays 1 throughout; lap_count increments on the following 0.
4. Lock loss. While locked, send 3,6,2.
   - err_count increments by 2; mismatch pulses twice; mon_state=01; locked=0.
   - Then 3,4,5,6 gives locked=1 again after 6 is sampled.
5. Gaps and saturation.
   - Hold code_valid=0 for 5 cycles mid-lock with code_in garbage: nothing changes.
   - With ERR_W=2, inject 5 bad steps across SLIP/LOCKED recovery: err_count holds at 3.
6. Reset and clear.
   - Assert Reset between edges while LOCKED: all outputs read 0 and mon_state=00 before the next Clk edge.
   - Pulse clr_cnt while a lap occurs: lap_count=0 after the edge.
